// File: rtl/branch_resolve_tracker_if.sv
// Prediction/resolution bundle between the fetch/decode stages and the
// branch resolve tracker. The master side drives IF/ID information and
// stall; the slave side (the tracker) returns redirect, flush, training
// and statistics signals.
interface branch_resolve_tracker_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic [31:0]      if_pc;
  logic             if_pred;
  logic [31:0]      id_pc;
  logic             is_branch;
  logic             is_taken;
  logic [31:0]      id_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall, if_pc, if_pred, id_pc, is_branch, is_taken, id_target,
    input  mispredict, redirect_pc, flush, upd_valid, upd_pc, upd_taken,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall, if_pc, if_pred, id_pc, is_branch, is_taken, id_target,
    output mispredict, redirect_pc, flush, upd_valid, upd_pc, upd_taken,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_tracker.sv
// Branch resolve tracker: carries each IF-stage prediction down a DELAY-deep
// queue so it lines up with the same instruction in ID, checks the resolved
// direction against it, and on a mispredict issues a redirect PC plus a
// FLUSH_CYCLES-long front-end flush. Also emits the predictor training tuple
// and keeps saturating resolution statistics.
module branch_resolve_tracker #(
  parameter int DELAY        = 7,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic                      clk,
  input logic                      reset,
  branch_resolve_tracker_if.slave  bus
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0]  FC_INIT = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, FLUSH} state_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Prediction queue; index 0 is the head, aligned with ID.
  logic [DELAY-1:0] q_vld;
  logic [31:0]      q_pc [DELAY];
  logic [DELAY-1:0] q_pred;

  state_t           state;
  logic [FC_W-1:0]  fcnt;
  logic             flush_q;
  logic             mispredict_q;
  logic [31:0]      redirect_q;
  logic             upd_valid_q;
  logic [31:0]      upd_pc_q;
  logic             upd_taken_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic hit;
  logic eff_pred;
  logic resolve;
  logic mis;
  logic flush_next;

  // A missing or misaligned head record counts as predicted not-taken;
  // branches seen while flushing are wrong-path and never resolve.
  always_comb begin
    hit      = q_vld[0] & (q_pc[0] == bus.id_pc);
    eff_pred = hit & q_pred[0];
    resolve  = bus.is_branch & (state == IDLE);
    mis      = resolve & (bus.is_taken != eff_pred);
  end

  // Flush value that this edge will register; gates the valid bit of the
  // instruction being captured from IF.
  always_comb begin
    flush_next = flush_q;
    if (mis) begin
      flush_next = 1'b1;
    end else if (state == FLUSH && fcnt == FC_ONE) begin
      flush_next = 1'b0;
    end
  end

  // Shift the prediction queue toward ID on every unstalled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_vld  <= '0;
      q_pred <= '0;
      for (int k = 0; k < DELAY; k++) begin
        q_pc[k] <= '0;
      end
    end else if (!bus.stall) begin
      for (int k = 0; k < DELAY - 1; k++) begin
        q_vld[k]  <= q_vld[k+1];
        q_pc[k]   <= q_pc[k+1];
        q_pred[k] <= q_pred[k+1];
      end
      q_vld[DELAY-1]  <= ~flush_next;
      q_pc[DELAY-1]   <= bus.if_pc;
      q_pred[DELAY-1] <= bus.if_pred;
    end
  end

  // Resolve FSM with registered redirect, flush, training and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fcnt          <= '0;
      flush_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_q    <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bus.stall) begin
      mispredict_q <= 1'b0;
      upd_valid_q  <= 1'b0;
    end else begin
      mispredict_q <= mis;
      upd_valid_q  <= resolve;
      case (state)
        IDLE: begin
          if (resolve) begin
            upd_pc_q     <= bus.id_pc;
            upd_taken_q  <= bus.is_taken;
            branch_cnt_q <= sat_inc(branch_cnt_q);
          end
          if (mis) begin
            redirect_q    <= bus.is_taken ? bus.id_target : bus.id_pc + 32'd4;
            mispred_cnt_q <= sat_inc(mispred_cnt_q);
            state         <= FLUSH;
            fcnt          <= FC_INIT;
            flush_q       <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt == FC_ONE) begin
            state   <= IDLE;
            fcnt    <= '0;
            flush_q <= 1'b0;
          end else begin
            fcnt <= fcnt - FC_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          fcnt    <= '0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.flush       = flush_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Testbench for branch_resolve_tracker: directed vectors with hand-computed
// expectations pushed into a scoreboard; a monitor pops and compares each
// training/mispredict event as the DUT presents it.
module tb_branch_resolve_tracker;
  localparam int DELAY        = 7;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic clk;
  logic reset;

  branch_resolve_tracker_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_tracker #(
    .DELAY(DELAY), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   fcount = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented training tuple against the scoreboard,
  // and count unstalled flush-high cycles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.flush && !bus.stall) fcount++;
      if (bus.upd_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_upd: upd_valid=1 pc=%h, expected none", bus.upd_pc);
        end else begin
          e = sb.pop_front();
          chk("upd_pc", bus.upd_pc, e.pc);
          chk("upd_taken", {31'd0, bus.upd_taken}, {31'd0, e.taken});
          chk("mispredict", {31'd0, bus.mispredict}, {31'd0, e.mis});
          if (e.mis) chk("redirect_pc", bus.redirect_pc, e.redir);
          chk("branch_cnt", bus.branch_cnt, e.bc);
          chk("mispred_cnt", bus.mispred_cnt, e.mc);
        end
      end else if (bus.mispredict) begin
        total++;
        bad++;
        $display("FAIL spurious_mis: mispredict=1 without upd_valid, expected 0");
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic taken, input logic mis,
                      input logic [31:0] redir, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.pc = pc; e.taken = taken; e.mis = mis; e.redir = redir; e.bc = bc; e.mc = mc;
    sb.push_back(e);
  endtask

  // Capture one prediction in IF, then resolve in ID DELAY cycles later.
  task automatic send(input logic [31:0] pc, input logic pred, input logic [31:0] idpc,
                      input logic taken, input logic [31:0] tgt, input logic emis,
                      input logic [31:0] eredir, input logic [31:0] ebc, input logic [31:0] emc);
    bus.if_pc = pc;
    bus.if_pred = pred;
    tick();
    bus.if_pc = 32'd0;
    bus.if_pred = 1'b0;
    repeat (DELAY - 1) tick();
    bus.id_pc = idpc;
    bus.is_branch = 1'b1;
    bus.is_taken = taken;
    bus.id_target = tgt;
    push(idpc, taken, emis, eredir, ebc, emc);
    tick();
    bus.is_branch = 1'b0;
    bus.is_taken = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, "_mispredict"}, {31'd0, bus.mispredict}, 32'd0);
    chk({tag, "_upd_valid"}, {31'd0, bus.upd_valid}, 32'd0);
    chk({tag, "_flush"}, {31'd0, bus.flush}, 32'd0);
    chk({tag, "_branch_cnt"}, bus.branch_cnt, bc);
    chk({tag, "_mispred_cnt"}, bus.mispred_cnt, mc);
  endtask

  initial begin
    int fbase;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.if_pc = '0;
    bus.if_pred = 1'b0;
    bus.id_pc = '0;
    bus.is_branch = 1'b0;
    bus.is_taken = 1'b0;
    bus.id_target = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("rst", 32'd0, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_upd_pc", bus.upd_pc, 32'd0);
    reset = 1'b1;
    repeat (10) tick();
    chk_idle_outputs("idle10", 32'd0, 32'd0);

    // Correctly predicted taken branch
    send(32'h100, 1'b1, 32'h100, 1'b1, 32'h0, 1'b0, 32'h0, 32'd1, 32'd0);
    chk("pred_ok_flush", {31'd0, bus.flush}, 32'd0);
    repeat (2) tick();

    // Predicted not-taken, resolved taken: redirect to target, flush 2 cycles,
    // wrong-path branches in ID ignored
    send(32'h100, 1'b0, 32'h100, 1'b1, 32'h2000, 1'b1, 32'h2000, 32'd2, 32'd1);
    fbase = fcount;
    bus.id_pc = 32'h500;
    bus.is_branch = 1'b1;
    bus.is_taken = 1'b1;
    bus.id_target = 32'h9000;
    repeat (2) tick();
    bus.is_branch = 1'b0;
    bus.is_taken = 1'b0;
    repeat (2) tick();
    chk("flush_len", fcount - fbase, 32'd2);
    chk("flush_end", {31'd0, bus.flush}, 32'd0);
    chk("wrongpath_branch_cnt", bus.branch_cnt, 32'd2);

    // Predicted taken, resolved not-taken: fall-through, including 32-bit wrap
    send(32'h3FC, 1'b1, 32'h3FC, 1'b0, 32'h7000, 1'b1, 32'h400, 32'd3, 32'd2);
    repeat (4) tick();
    send(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h7000, 1'b1, 32'h0, 32'd4, 32'd3);
    repeat (4) tick();

    // Head PC misaligned with ID: treated as predicted not-taken
    send(32'h200, 1'b1, 32'h204, 1'b1, 32'h3000, 1'b1, 32'h3000, 32'd5, 32'd4);
    repeat (4) tick();

    // Back-to-back correctly predicted branches
    bus.if_pc = 32'h600; bus.if_pred = 1'b1;
    tick();
    bus.if_pc = 32'h604; bus.if_pred = 1'b0;
    tick();
    bus.if_pc = 32'h0; bus.if_pred = 1'b0;
    repeat (DELAY - 2) tick();
    bus.id_pc = 32'h600; bus.is_branch = 1'b1; bus.is_taken = 1'b1;
    push(32'h600, 1'b1, 1'b0, 32'h0, 32'd6, 32'd4);
    tick();
    chk("b2b_first_valid", {31'd0, bus.upd_valid}, 32'd1);
    bus.id_pc = 32'h604; bus.is_branch = 1'b1; bus.is_taken = 1'b0;
    push(32'h604, 1'b0, 1'b0, 32'h0, 32'd7, 32'd4);
    tick();
    chk("b2b_second_valid", {31'd0, bus.upd_valid}, 32'd1);
    bus.is_branch = 1'b0;
    repeat (2) tick();

    // Stall for 3 cycles mid-flush
    send(32'h700, 1'b0, 32'h700, 1'b1, 32'h4000, 1'b1, 32'h4000, 32'd8, 32'd5);
    fbase = fcount;
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flush_held", {31'd0, bus.flush}, 32'd1);
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_flush_end", {31'd0, bus.flush}, 32'd0);
    chk("stall_flush_len", fcount - fbase, 32'd2);
    chk("stall_branch_cnt", bus.branch_cnt, 32'd8);
    repeat (2) tick();

    // Fill queue with taken predictions for 0x900, mispredict, reset mid-flush
    bus.if_pc = 32'h900; bus.if_pred = 1'b1;
    repeat (DELAY) tick();
    bus.id_pc = 32'h900; bus.is_branch = 1'b1; bus.is_taken = 1'b0;
    push(32'h900, 1'b0, 1'b1, 32'h904, 32'd9, 32'd6);
    tick();
    bus.is_branch = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_reset_flush", {31'd0, bus.flush}, 32'd1);
    reset = 1'b0;
    #1;
    chk_idle_outputs("midflush_rst", 32'd0, 32'd0);
    chk("midflush_rst_redirect", bus.redirect_pc, 32'd0);
    // A cleared queue makes the head invalid: 0x900 taken now mispredicts
    bus.if_pc = 32'h0; bus.if_pred = 1'b0;
    bus.id_pc = 32'h900; bus.is_branch = 1'b1; bus.is_taken = 1'b1;
    bus.id_target = 32'hA000;
    push(32'h900, 1'b1, 1'b1, 32'hA000, 32'd1, 32'd1);
    #1;
    reset = 1'b1;
    tick();
    bus.is_branch = 1'b0;
    bus.is_taken = 1'b0;
    repeat (4) tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_tracker.md
Name: branch_resolve_tracker

Overview:
- Consumer end of the fetch-stage prediction interface. Captures every IF-stage prediction (pc, predicted direction) and carries it down a DELAY-deep pipeline.
- When the branch resolves in ID, compares the resolved outcome against the carried prediction.
- On a mismatch, issues a redirect PC and a multi-cycle front-end flush, emits the predictor training tuple, and keeps resolution statistics.

Parameters:
DELAY, 7, cycles between IF capture and the same instruction reaching ID resolution (min 2)
FLUSH_CYCLES, 2, cycles flush is held after a mispredict (min 1)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
stall  input  1  pipeline stall; freezes all state when high
if_pc  input  32  PC of instruction in IF
if_pred  input  1  predicted direction for if_pc (1 = taken)
id_pc  input  32  PC of instruction in ID
is_branch  input  1  ID instruction is a conditional branch
is_taken  input  1  resolved direction in ID
id_target  input  32  resolved taken target in ID
mispredict  output  1  one-cycle pulse: misprediction detected
redirect_pc  output  32  correct fetch PC, valid while mispredict is high
flush  output  1  front-end flush, held FLUSH_CYCLES cycles
upd_valid  output  1  training tuple valid (one cycle per resolved branch)
upd_pc  output  32  PC of resolved branch
upd_taken  output  1  resolved direction
branch_cnt  output  CNT_W  count of resolved branches
mispred_cnt  output  CNT_W  count of mispredictions

Behaviour:
- Reset (async, active-low):
  - All queue entries cleared, including valid bits.
  - FSM = IDLE, flush counter = 0.
  - All outputs 0, counters 0.
- Queue: DELAY entries of {valid, pc[31:0], pred}. Each non-stall cycle:
  - entry[DELAY-1] <= {~flush_next, if_pc, if_pred}.
  - entry[k] <= entry[k+1].
  - entry[0] is the head, aligned with ID.
- Match:
  - hit = entry[0].valid & (entry[0].pc == id_pc).
  - eff_pred = hit ? entry[0].pred : 0 (a missing or misaligned record is treated as predicted not-taken).
- Resolve, evaluated combinationally and registered on a non-stall edge when is_branch = 1 and FSM = IDLE:
  - Training tuple: upd_valid <= 1, upd_pc <= id_pc, upd_taken <= is_taken.
  - branch_cnt increments, saturating at all-ones.
  - If is_taken != eff_pred:
    - mispredict <= 1.
    - redirect_pc <= is_taken ? id_target : id_pc + 4 (32-bit wrap).
    - mispred_cnt increments, saturating.
    - FSM -> FLUSH, counter <= FLUSH_CYCLES.
- Latency: outputs appear one clock after the resolving ID cycle. mispredict and upd_valid are single-cycle pulses; otherwise 0.
- FSM IDLE: flush = 0; transitions to FLUSH on a mispredict as above.
- FSM FLUSH:
  - flush = 1.
  - Counter decrements each non-stall cycle.
  - At counter == 1 with no stall, returns to IDLE the next edge. flush is therefore high exactly FLUSH_CYCLES unstalled cycles.
- During FLUSH:
  - Branches in ID are wrong-path: no update, no count, no mispredict.
  - Entries shifted in get valid = 0.
  - flush_next denotes the registered flush value for that edge.
- Stall:
  - Queue, FSM, counter and statistics hold.
  - Pulse outputs (mispredict, upd_valid) deassert during stall and are not replayed.
  - redirect_pc holds its last value.
- Reset mid-FLUSH: returns to IDLE immediately, flush drops asynchronously.
- Back-to-back branches in IDLE, each resolved correctly: upd_valid is high on consecutive cycles.

Test Plan:
- Reset then 10 unstalled cycles, no branches -> all outputs 0, counters 0, flush 0.
- if_pc=0x100, if_pred=1; DELAY cycles later id_pc=0x100, is_branch=1, is_taken=1 -> next cycle upd_valid=1, upd_pc=0x100, upd_taken=1, mispredict=0, branch_cnt=1.
- Same alignment with if_pred=0; ID is_taken=1, id_target=0x2000 -> mispredict pulse, redirect_pc=0x2000, flush high exactly 2 cycles, mispred_cnt=1. A branch presented in ID during those 2 cycles -> ignored, branch_cnt unchanged.
- Predicted taken at 0x3FC, resolved not-taken -> redirect_pc=0x400. Repeat with id_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- id_pc mismatches the queue head (0x200 vs 0x204), is_taken=1 -> eff_pred=0, mispredict=1.
- Assert stall for 3 cycles mid-FLUSH -> flush stays high, counter frozen, total flush-high unstalled cycles = 2. Assert reset mid-FLUSH -> flush=0 immediately, queue invalid.
